i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver_if.sv | 29 ++
 rtl/i2s_receiver.sv | 79 +++++++
 tb/tb_i2s_receiver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: I2S serial input plus held sample-pair handshake and error flags
// Signals:
//   word_select, sound_bit_in  I2S WS (0 = left, 1 = right) and MSB-first serial data
//   clear_errors               single-cycle pulse clearing the sticky error flags
//   sample_ready               consumer accepts the held pair
//   left_sample, right_sample  held channel words
//   sample_valid               held pair is valid
//   short_word_err             sticky: a channel word ended before DATA_WIDTH bits
//   overrun_err                sticky: a completed pair was dropped while the holding register was full
// Modports: master = receiver side, slave = source/consumer side.
interface i2s_receiver_if #(parameter int DATA_WIDTH = 16);
  logic word_select;
  logic sound_bit_in;
  logic clear_errors;
  logic sample_ready;
  logic [DATA_WIDTH-1:0] left_sample;
  logic [DATA_WIDTH-1:0] right_sample;
  logic sample_valid;
  logic short_word_err;
  logic overrun_err;
  modport master (
    input  word_select, sound_bit_in, clear_errors, sample_ready,
    output left_sample, right_sample, sample_valid, short_word_err, overrun_err
  );
  modport slave (
    output word_select, sound_bit_in, clear_errors, sample_ready,
    input  left_sample, right_sample, sample_valid, short_word_err, overrun_err
  );
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S deserialiser delivering left/right word pairs through a valid/ready holding register
// Ports:
//   s_clk  bit clock; every input sampled and all state updated on its rising edge
//   reset  synchronous active-high reset
//   bus    i2s_receiver_if.master carrying serial input, sample handshake and error flags
module i2s_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input logic s_clk,
  input logic reset,
  i2s_receiver_if.master bus
);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] FULL = IW'(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
  state_t state_q, state_d;
  logic ws_d, left_ok;
  logic ws_change, enter_left, short_evt, cap_left, cap_right;
  logic left_done, pair_done, xfer, load, overrun_evt;
  logic [IW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] left_shift, right_shift, right_word;
  // The change edge itself carries no data; bits arrive on the following edges
  // and the index saturates at FULL so trailing bits are ignored.
  always_comb begin
    ws_change = bus.word_select != ws_d;
    enter_left = ws_change && !bus.word_select;
    state_d = state_q;
    short_evt = 1'b0;
    cap_left = 1'b0;
    cap_right = 1'b0;
    if (state_q == SYNC) state_d = enter_left ? LEFT : SYNC;
    else if (ws_change) begin
      state_d = bus.word_select ? RIGHT : LEFT;
      short_evt = bit_idx < FULL;
    end else begin
      cap_left = state_q == LEFT && bit_idx < FULL;
      cap_right = state_q == RIGHT && bit_idx < FULL;
    end
    left_done = cap_left && bit_idx == LAST;
    pair_done = cap_right && bit_idx == LAST && left_ok;
    right_word = {right_shift[DATA_WIDTH-2:0], bus.sound_bit_in};
    xfer = bus.sample_valid && bus.sample_ready;
    // A pair loads when the register is empty or is being emptied on this edge.
    load = pair_done && (!bus.sample_valid || xfer);
    overrun_evt = pair_done && !load;
  end
  always_ff @(posedge s_clk) begin
    if (reset) begin
      state_q <= SYNC;
      ws_d <= 1'b0;
      bit_idx <= '0;
      left_ok <= 1'b0;
      left_shift <= '0;
      right_shift <= '0;
      bus.left_sample <= '0;
      bus.right_sample <= '0;
      bus.sample_valid <= 1'b0;
      bus.short_word_err <= 1'b0;
      bus.overrun_err <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_d <= bus.word_select;
      bit_idx <= ws_change ? '0 : bit_idx + IW'(cap_left || cap_right);
      if (cap_left) left_shift <= {left_shift[DATA_WIDTH-2:0], bus.sound_bit_in};
      if (cap_right) right_shift <= right_word;
      // left_ok marks a complete left word waiting for its right partner in this frame.
      left_ok <= (enter_left || pair_done) ? 1'b0 : (left_done || left_ok);
      if (load) begin
        bus.left_sample <= left_shift;
        bus.right_sample <= right_word;
      end
      bus.sample_valid <= load || (bus.sample_valid && !xfer);
      // Error events win over a simultaneous clear.
      bus.short_word_err <= short_evt || (bus.short_word_err && !bus.clear_errors);
      bus.overrun_err <= overrun_evt || (bus.overrun_err && !bus.clear_errors);
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed self-checking bench for i2s_receiver
module tb_i2s_receiver;
  logic s_clk, reset, mon_en;
  int n_chk, n_fail;
  logic [31:0] mon_q[$];
  i2s_receiver_if #(.DATA_WIDTH(16)) bus ();
  i2s_receiver #(.DATA_WIDTH(16)) dut (.s_clk(s_clk), .reset(reset), .bus(bus));
  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;
  always @(negedge s_clk)
    if (mon_en && bus.sample_valid && bus.sample_ready) mon_q.push_back({bus.left_sample, bus.right_sample});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask
  task automatic send_half(input logic ws, input logic [15:0] d, input int n, input logic rb,
                           input logic re, input logic ce);
    bus.word_select = ws;
    bus.sound_bit_in = 1'b0;
    bus.sample_ready = rb;
    bus.clear_errors = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      bus.sound_bit_in = d[15-i];
      if (i == n - 1) begin
        bus.sample_ready = re;
        bus.clear_errors = ce;
      end
      tick();
    end
    bus.sample_ready = rb;
    bus.clear_errors = 1'b0;
  endtask
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic rb,
                            input logic re, input logic ce);
    send_half(1'b0, l, 16, rb, rb, 1'b0);
    send_half(1'b1, r, 16, rb, re, ce);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] lv;
    n_chk = 0;
    n_fail = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    bus.word_select = 1'b0;
    bus.sound_bit_in = 1'b0;
    bus.sample_ready = 1'b0;
    bus.clear_errors = 1'b0;
    repeat (3) tick();
    chk("rst_left", bus.left_sample, 0);
    chk("rst_right", bus.right_sample, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_short", bus.short_word_err, 0);
    chk("rst_overrun", bus.overrun_err, 0);
    reset = 1'b0;
    send_half(1'b1, 16'h0000, 16, 1'b0, 1'b0, 1'b0);
    chk("sync_valid", bus.sample_valid, 0);
    send_half(1'b0, 16'hA5C3, 16, 1'b0, 1'b0, 1'b0);
    send_half(1'b1, 16'h0000, 15, 1'b0, 1'b0, 1'b0);
    chk("nom_pre_valid", bus.sample_valid, 0);
    bus.sound_bit_in = 1'b0;
    tick();
    chk("nom_valid", bus.sample_valid, 1);
    chk("nom_left", bus.left_sample, 16'hA5C3);
    chk("nom_right", bus.right_sample, 16'h0000);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    chk("nom_drain", bus.sample_valid, 0);
    send_frame(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    chk("sim_first_valid", bus.sample_valid, 1);
    send_frame(16'h4321, 16'h8765, 1'b0, 1'b1, 1'b0);
    chk("sim_valid", bus.sample_valid, 1);
    chk("sim_left", bus.left_sample, 16'h4321);
    chk("sim_right", bus.right_sample, 16'h8765);
    chk("sim_overrun", bus.overrun_err, 0);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    chk("sim_drain", bus.sample_valid, 0);
    mon_en = 1'b1;
    for (int i = 0; i < 42; i++) begin
      lv = 16'((i % 41) * 100);
      send_frame(lv, ~lv, 1'b1, 1'b1, 1'b0);
    end
    tick();
    mon_en = 1'b0;
    chk("ramp_count", mon_q.size(), 42);
    for (int i = 0; i < 42 && i < mon_q.size(); i++) begin
      lv = 16'((i % 41) * 100);
      chk($sformatf("ramp_%0d", i), mon_q[i], {lv, ~lv});
    end
    chk("ramp_short", bus.short_word_err, 0);
    chk("ramp_overrun", bus.overrun_err, 0);
    chk("ramp_idle", bus.sample_valid, 0);
    bus.sample_ready = 1'b0;
    send_frame(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
    chk("bp_valid1", bus.sample_valid, 1);
    chk("bp_left1", bus.left_sample, 16'h1111);
    chk("bp_ovr1", bus.overrun_err, 0);
    send_frame(16'h2222, 16'h2222, 1'b0, 1'b0, 1'b0);
    chk("bp_left2", bus.left_sample, 16'h1111);
    chk("bp_right2", bus.right_sample, 16'h1111);
    chk("bp_valid2", bus.sample_valid, 1);
    chk("bp_ovr2", bus.overrun_err, 1);
    bus.sample_ready = 1'b1;
    tick();
    repeat (3) tick();
    bus.sample_ready = 1'b0;
    chk("bp_after_valid", bus.sample_valid, 0);
    chk("bp_after_left", bus.left_sample, 16'h1111);
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    chk("bp_clear", bus.overrun_err, 0);
    send_half(1'b0, 16'hFFFF, 10, 1'b0, 1'b0, 1'b0);
    send_half(1'b1, 16'hABCD, 16, 1'b0, 1'b0, 1'b0);
    chk("short_err", bus.short_word_err, 1);
    chk("short_valid", bus.sample_valid, 0);
    send_frame(16'h7FFF, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    chk("short_next_valid", bus.sample_valid, 1);
    chk("short_next_left", bus.left_sample, 16'h7FFF);
    chk("short_next_right", bus.right_sample, 16'h0F0F);
    chk("short_sticky", bus.short_word_err, 1);
    bus.sample_ready = 1'b1;
    bus.clear_errors = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    bus.clear_errors = 1'b0;
    chk("short_clear", bus.short_word_err, 0);
    chk("short_drain", bus.sample_valid, 0);
    send_frame(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0);
    send_frame(16'h9999, 16'h8888, 1'b0, 1'b0, 1'b1);
    chk("clr_ovr_win", bus.overrun_err, 1);
    chk("clr_ovr_left", bus.left_sample, 16'h1357);
    chk("clr_ovr_valid", bus.sample_valid, 1);
    send_half(1'b0, 16'hFFFF, 5, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_valid", bus.sample_valid, 0);
    chk("midrst_ovr", bus.overrun_err, 0);
    chk("midrst_left", bus.left_sample, 0);
    chk("midrst_right", bus.right_sample, 0);
    reset = 1'b0;
    send_half(1'b0, 16'hFFFF, 8, 1'b0, 1'b0, 1'b0);
    send_half(1'b1, 16'hFFFF, 16, 1'b0, 1'b0, 1'b0);
    chk("start_valid", bus.sample_valid, 0);
    send_frame(16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 1'b0);
    chk("start_pair_valid", bus.sample_valid, 1);
    chk("start_left", bus.left_sample, 16'hBEEF);
    chk("start_right", bus.right_sample, 16'hCAFE);
    chk("start_short", bus.short_word_err, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
